// File: rtl/fluid_board_valve_driver_if.sv
// Request/drive bundle between the PIO output register and the peak-and-hold valve driver.
interface fluid_board_valve_driver_if #(
  parameter int CHANNELS = 16,
  parameter int PWM_W    = 8
);
  logic [CHANNELS-1:0] req_in;
  logic                enable;
  logic [PWM_W-1:0]    hold_duty;
  logic [CHANNELS-1:0] drive_out;
  logic [CHANNELS-1:0] peak_active;
  logic [CHANNELS-1:0] cooling;

  modport master (
    output req_in, enable, hold_duty,
    input  drive_out, peak_active, cooling
  );

  modport slave (
    input  req_in, enable, hold_duty,
    output drive_out, peak_active, cooling
  );
endinterface

// File: rtl/fluid_board_valve_driver.sv
// Per-channel peak-and-hold solenoid driver: full-on PEAK, PWM HOLD at a shared duty,
// and an enforced COOL period after release before a channel may re-energise.
module fluid_board_valve_driver #(
  parameter int CHANNELS       = 16,
  parameter int PEAK_CYCLES    = 5000,
  parameter int MIN_OFF_CYCLES = 1000,
  parameter int PWM_PERIOD     = 256,
  parameter int CNT_W          = 16,
  parameter int PWM_W          = 8
) (
  input logic                       clk,
  input logic                       reset_n,
  fluid_board_valve_driver_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEAK = 2'd1,
    ST_HOLD = 2'd2,
    ST_COOL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PEAK_LOAD = CNT_W'(PEAK_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(MIN_OFF_CYCLES - 1);
  localparam logic [PWM_W-1:0] PWM_LAST  = PWM_W'(PWM_PERIOD - 1);

  logic [PWM_W-1:0]    r_pwm_cnt;
  logic                w_pwm_on;
  logic [CHANNELS-1:0] w_go;

  // Duty at or above the period never fails the compare, so hold drive stays high.
  assign w_pwm_on = (r_pwm_cnt < bus.hold_duty);
  assign w_go     = bus.req_in & {CHANNELS{bus.enable}};

  // Shared free-running hold-phase PWM counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else if (r_pwm_cnt >= PWM_LAST) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_drive;
    logic             r_peak;
    logic             r_cool;

    assign bus.drive_out[g]   = r_drive;
    assign bus.peak_active[g] = r_peak;
    assign bus.cooling[g]     = r_cool;

    // Channel state machine; outputs are registered alongside the next state.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= ST_IDLE;
        r_timer <= '0;
        r_drive <= 1'b0;
        r_peak  <= 1'b0;
        r_cool  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_go[g]) begin
              r_state <= ST_PEAK;
              r_timer <= PEAK_LOAD;
              r_drive <= 1'b1;
              r_peak  <= 1'b1;
              r_cool  <= 1'b0;
            end else begin
              r_drive <= 1'b0;
              r_peak  <= 1'b0;
              r_cool  <= 1'b0;
            end
          end
          ST_PEAK: begin
            if (!w_go[g]) begin
              r_state <= ST_COOL;
              r_timer <= COOL_LOAD;
              r_drive <= 1'b0;
              r_peak  <= 1'b0;
              r_cool  <= 1'b1;
            end else if (r_timer == '0) begin
              r_state <= ST_HOLD;
              r_drive <= w_pwm_on;
              r_peak  <= 1'b0;
              r_cool  <= 1'b0;
            end else begin
              r_timer <= r_timer - CNT_W'(1);
              r_drive <= 1'b1;
              r_peak  <= 1'b1;
              r_cool  <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (!w_go[g]) begin
              r_state <= ST_COOL;
              r_timer <= COOL_LOAD;
              r_drive <= 1'b0;
              r_peak  <= 1'b0;
              r_cool  <= 1'b1;
            end else begin
              r_drive <= w_pwm_on;
              r_peak  <= 1'b0;
              r_cool  <= 1'b0;
            end
          end
          ST_COOL: begin
            // Request is deliberately ignored here; IDLE must be visited before re-arming.
            if (r_timer == '0) begin
              r_state <= ST_IDLE;
              r_cool  <= 1'b0;
            end else begin
              r_timer <= r_timer - CNT_W'(1);
              r_cool  <= 1'b1;
            end
            r_drive <= 1'b0;
            r_peak  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_drive <= 1'b0;
            r_peak  <= 1'b0;
            r_cool  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fluid_board_valve_driver.sv
// Directed vector bench for the peak-and-hold valve driver (PEAK=10, COOL=4, PWM period 8).
module tb_fluid_board_valve_driver;
  localparam int CH = 16;
  localparam int PW = 8;
  localparam int PERIOD = 8;

  typedef struct {
    logic [CH-1:0] req;
    logic          en;
    logic [PW-1:0] duty;
    logic [CH-1:0] exp_drive;
    logic [CH-1:0] exp_peak;
    logic [CH-1:0] exp_cool;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  fluid_board_valve_driver_if #(.CHANNELS(CH), .PWM_W(PW)) bus ();

  fluid_board_valve_driver #(
    .CHANNELS(CH), .PEAK_CYCLES(10), .MIN_OFF_CYCLES(4),
    .PWM_PERIOD(PERIOD), .CNT_W(16), .PWM_W(PW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Vector v (1-based) sees pwm_cnt == (v-1) % PERIOD before its edge; hold channels follow that.
  task automatic add(input int n, input logic [CH-1:0] req, input logic en, input logic [PW-1:0] duty,
                     input logic [CH-1:0] fixed_drive, input logic [CH-1:0] hold_mask,
                     input logic [CH-1:0] peak, input logic [CH-1:0] cool);
    for (int k = 0; k < n; k++) begin
      vec_t e;
      int   v;
      v = vecs.size() + 1;
      e.req = req; e.en = en; e.duty = duty;
      e.exp_drive = fixed_drive | ((((v - 1) % PERIOD) < int'(duty)) ? hold_mask : '0);
      e.exp_peak = peak;
      e.exp_cool = cool;
      vecs.push_back(e);
    end
  endtask

  initial begin
    bus.req_in = '0;
    bus.enable = 1'b1;
    bus.hold_duty = 8'd3;

    // activation, hold, release/cooldown with re-request during COOL
    add(10, 16'h0001, 1'b1, 8'd3,   16'h0001, 16'h0000, 16'h0001, 16'h0000);
    add(30, 16'h0001, 1'b1, 8'd3,   16'h0000, 16'h0001, 16'h0000, 16'h0000);
    add(2,  16'h0000, 1'b1, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'h0001);
    add(2,  16'h0001, 1'b1, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'h0001);
    add(1,  16'h0001, 1'b1, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(10, 16'h0001, 1'b1, 8'd3,   16'h0001, 16'h0000, 16'h0001, 16'h0000);
    add(4,  16'h0000, 1'b1, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'h0001);
    add(1,  16'h0000, 1'b1, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'h0000);
    // short pulse on channel 5
    add(3,  16'h0020, 1'b1, 8'd3,   16'h0020, 16'h0000, 16'h0020, 16'h0000);
    add(4,  16'h0000, 1'b1, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'h0020);
    add(2,  16'h0000, 1'b1, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'h0000);
    // duty edges and mid-hold duty change
    add(10, 16'h0001, 1'b1, 8'd0,   16'h0001, 16'h0000, 16'h0001, 16'h0000);
    add(16, 16'h0001, 1'b1, 8'd0,   16'h0000, 16'h0001, 16'h0000, 16'h0000);
    add(16, 16'h0001, 1'b1, 8'd8,   16'h0000, 16'h0001, 16'h0000, 16'h0000);
    add(16, 16'h0001, 1'b1, 8'd255, 16'h0000, 16'h0001, 16'h0000, 16'h0000);
    add(2,  16'h0001, 1'b1, 8'd3,   16'h0000, 16'h0001, 16'h0000, 16'h0000);
    add(14, 16'h0001, 1'b1, 8'd6,   16'h0000, 16'h0001, 16'h0000, 16'h0000);
    // global enable drop with mixed PEAK/HOLD
    add(2,  16'hFFFF, 1'b1, 8'd3,   16'hFFFE, 16'h0001, 16'hFFFE, 16'h0000);
    add(4,  16'hFFFF, 1'b0, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    add(4,  16'hFFFF, 1'b0, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1,  16'h0000, 1'b1, 8'd3,   16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1,  16'h00F3, 1'b1, 8'd3,   16'h00F3, 16'h0000, 16'h00F3, 16'h0000);

    repeat (3) @(posedge clk);
    #1;
    check("reset_drive", 0, bus.drive_out, 16'h0000);
    check("reset_peak",  0, bus.peak_active, 16'h0000);
    check("reset_cool",  0, bus.cooling, 16'h0000);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.req_in = vecs[i].req;
      bus.enable = vecs[i].en;
      bus.hold_duty = vecs[i].duty;
      @(posedge clk);
      #1;
      check("drive_out",   i + 1, bus.drive_out,   vecs[i].exp_drive);
      check("peak_active", i + 1, bus.peak_active, vecs[i].exp_peak);
      check("cooling",     i + 1, bus.cooling,     vecs[i].exp_cool);
      @(negedge clk);
    end

    // asynchronous reset between edges while drive_out is 0x00F3
    check("pre_reset_drive", 0, bus.drive_out, 16'h00F3);
    reset_n = 1'b0;
    #1;
    check("async_rst_drive", 0, bus.drive_out, 16'h0000);
    check("async_rst_peak",  0, bus.peak_active, 16'h0000);
    check("async_rst_cool",  0, bus.cooling, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      check("restart_drive", k, bus.drive_out, 16'h00F3);
      check("restart_peak",  k, bus.peak_active, 16'h00F3);
    end
    // pwm_cnt restarted at 0: 11th edge sees 2 (on), 12th sees 3 (off)
    @(posedge clk);
    #1;
    check("restart_hold_peak",  11, bus.peak_active, 16'h0000);
    check("restart_hold_drive", 11, bus.drive_out, 16'h00F3);
    @(posedge clk);
    #1;
    check("restart_hold_drive", 12, bus.drive_out, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fluid_board_valve_driver.md
Name: fluid_board_valve_driver

Overview:
- Peak-and-hold solenoid driver that sits directly downstream of the 16-bit PIO output register.
- Each PIO bit is a level request for one valve or pump channel.
- For every channel the block drives full-on for a fixed peak time, then PWM at a programmable hold duty.
- After release it enforces a minimum off time before the channel can re-energise.

Parameters:
CHANNELS, 16, number of channels; equals PIO output width.
PEAK_CYCLES, 5000, clocks of full-on drive after activation; legal range 1..2^CNT_W-1.
MIN_OFF_CYCLES, 1000, clocks a channel is forced off after release; legal range 1..2^CNT_W-1.
PWM_PERIOD, 256, hold-phase PWM period in clocks; legal range 2..2^PWM_W.
CNT_W, 16, width of per-channel timer.
PWM_W, 8, width of PWM counter and hold_duty.

Ports:
clk  in  1  system clock, single clock domain.
reset_n  in  1  asynchronous, active-low reset.
req_in  in  CHANNELS  per-channel level request; driven by the PIO out_port in the same clock domain, no synchroniser.
enable  in  1  global drive enable (safety); low forces release of all channels.
hold_duty  in  PWM_W  hold-phase on-count per PWM period; sampled every clock.
drive_out  out  CHANNELS  registered gate drive to the valve FETs.
peak_active  out  CHANNELS  registered; 1 while the channel is in PEAK.
cooling  out  CHANNELS  registered; 1 while the channel is in COOL.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All channels go to IDLE; timers and PWM counter clear to 0.
  - drive_out, peak_active and cooling are 0.
  - Reset asserted mid-PEAK, mid-HOLD or mid-COOL drops drive_out to 0 immediately, with no cool-down enforced.
- PWM counter: shared, free-running 0..PWM_PERIOD-1, wraps to 0. Runs regardless of channel state.
- pwm_on = (pwm_cnt < hold_duty):
  - hold_duty=0 gives hold drive always 0.
  - hold_duty>=PWM_PERIOD gives hold drive always 1.
- Each channel is an independent state machine. All transitions, timer updates and outputs are registered on the same clk edge.
  - IDLE (drive 0): if req & enable, go to PEAK and load timer with PEAK_CYCLES-1.
  - PEAK (drive 1):
    - if !req | !enable, go to COOL and load timer with MIN_OFF_CYCLES-1;
    - else if timer==0, go to HOLD;
    - else timer decrements.
  - HOLD (drive = pwm_on for the pwm_cnt value current at that edge): if !req | !enable, go to COOL and load timer with MIN_OFF_CYCLES-1.
  - COOL (drive 0): req is ignored. If timer==0, go to IDLE; else timer decrements.
- Latency:
  - req rising before edge k (IDLE, enable=1) gives drive_out=1 after edge k.
  - Full-on lasts exactly PEAK_CYCLES clocks when req is held.
  - req falling before edge k (PEAK/HOLD) gives drive_out=0 after edge k.
- COOL lasts exactly MIN_OFF_CYCLES clocks. IDLE is then occupied for at least one clock, so the earliest re-drive is MIN_OFF_CYCLES+1 clocks after release.
- A request pulse shorter than PEAK_CYCLES still produces a full COOL period.
- enable low forces every PEAK/HOLD channel to COOL on the next edge. IDLE channels stay IDLE. COOL timers keep counting.
- Simultaneous activation of all channels is allowed; there is no staggering.
- peak_active = (state==PEAK); cooling = (state==COOL).

Test Plan:
Common bench settings: PEAK_CYCLES=10, MIN_OFF_CYCLES=4, PWM_PERIOD=8, hold_duty=3, enable=1.
1. Basic activation: req_in=0x0001 at cycle 0, held 40 clocks.
   - drive_out[0]=1 from cycle 1 for exactly 10 clocks; peak_active[0]=1 over the same window.
   - Then HOLD: drive_out[0] is high 3 of every 8 clocks, aligned to pwm_cnt 0..2.
2. Release and cooldown: drop req_in[0] during HOLD.
   - Next edge: drive_out[0]=0, cooling[0]=1 for exactly 4 clocks.
   - Re-asserting req_in[0] during COOL gives no drive.
   - Req held through COOL: drive resumes 1 clock after IDLE is reached.
3. Short pulse: req_in[5] high for 3 clocks.
   - drive_out[5] high for 3 clocks, then cooling[5]=1 for 4 clocks.
   - No HOLD phase occurs.
4. Duty edges:
   - hold_duty=0: HOLD drive constantly 0.
   - hold_duty=8 and hold_duty=255: HOLD drive constantly 1.
   - hold_duty changed mid-HOLD: new duty applies at the next comparison.
5. Global enable: req_in=0xFFFF, channels in mixed PEAK/HOLD, enable deasserted.
   - All drive_out bits 0 next edge; cooling=0xFFFF for 4 clocks; channels return to IDLE.
   - With enable still low, no channel restarts.
6. Async reset mid-operation: assert reset_n=0 mid-edge while drive_out=0x00F3.
   - drive_out, peak_active and cooling go to 0 without a clock edge.
   - After release with req_in held: full 10-clock PEAK restarts 1 clock after the first edge.
